// File: rtl/ex_stage.sv
// MIPS32 execute stage: single-cycle ALU, HI/LO write request and an optional 32-iteration
// restoring divider for DIV/DIVU, compiled in only when EX_DIV_EN is defined.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  waddr_i,
    input  logic        wr_en_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [4:0]  waddr_o,
    output logic        wr_en_o,
    output logic [31:0] wdata_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o,
    output logic [1:0]  dbg_state
);
    localparam logic [7:0] OP_AND  = 8'b0010_0100, OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110, OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100, OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011, OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUBU = 8'b0010_0011, OP_SLT  = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU = 8'b0010_1011, OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI = 8'b0001_0001, OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO = 8'b0001_0011, OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;
    localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE = 3'b011, SEL_ARITH = 3'b100;

    logic [31:0] logic_res, shift_res, arith_res, move_res;
    logic        is_div, is_mt;
    logic        div_stall, div_done;
    logic [31:0] div_quot, div_rem;

    assign is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign is_mt  = (aluop_i == OP_MTHI) || (aluop_i == OP_MTLO);

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        move_res  = '0;
        case (aluop_i)
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
            OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
            OP_SRA:  shift_res = 32'($signed(reg2_i) >>> reg1_i[4:0]);
            OP_ADDU: arith_res = reg1_i + reg2_i;
            OP_SUBU: arith_res = reg1_i - reg2_i;
            OP_SLT:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            OP_SLTU: arith_res = {31'd0, reg1_i < reg2_i};
            OP_MFHI: move_res  = hi_i;
            OP_MFLO: move_res  = lo_i;
            default: ;
        endcase
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIV_ZERO = 2'd1,
        S_DIV_ON   = 2'd2,
        S_DIV_END  = 2'd3
    } div_state_t;

    div_state_t  state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] dvd_q, dvs_q, rem_q;
    logic        neg_quot, neg_rem;
    logic        div_signed;
    logic [31:0] a_mag, b_mag;
    logic [32:0] trial;

    assign div_signed = (aluop_i == OP_DIV);
    assign a_mag = (div_signed && reg1_i[31]) ? -reg1_i : reg1_i;
    assign b_mag = (div_signed && reg2_i[31]) ? -reg2_i : reg2_i;
    // Partial remainder shifted left by the next dividend bit, minus the divisor; bit 32 is the borrow.
    assign trial = {rem_q, dvd_q[31]} - {1'b0, dvs_q};

    always_comb begin
        state_nxt = state;
        div_stall = 1'b0;
        div_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_div) begin
                    div_stall = 1'b1;
                    state_nxt = (reg2_i == 32'd0) ? S_DIV_ZERO : S_DIV_ON;
                end
            end
            S_DIV_ZERO: begin
                div_stall = 1'b1;
                state_nxt = S_DIV_END;
            end
            S_DIV_ON: begin
                div_stall = 1'b1;
                if (cnt == 6'd31) state_nxt = S_DIV_END;
            end
            S_DIV_END: begin
                div_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
            div_stall = 1'b0;
            div_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (is_div) begin
                            dvd_q    <= a_mag;
                            dvs_q    <= b_mag;
                            rem_q    <= '0;
                            cnt      <= '0;
                            neg_quot <= div_signed && (reg1_i[31] ^ reg2_i[31]);
                            neg_rem  <= div_signed && reg1_i[31];
                        end
                    end
                    S_DIV_ZERO: begin
                        dvd_q <= '0;
                        rem_q <= '0;
                    end
                    S_DIV_ON: begin
                        cnt <= cnt + 6'd1;
                        if (!trial[32]) begin
                            rem_q <= trial[31:0];
                            dvd_q <= {dvd_q[30:0], 1'b1};
                        end else begin
                            rem_q <= {rem_q[30:0], dvd_q[31]};
                            dvd_q <= {dvd_q[30:0], 1'b0};
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

    assign div_quot  = neg_quot ? -dvd_q : dvd_q;
    assign div_rem   = neg_rem ? -rem_q : rem_q;
    assign dbg_state = state;
`else
    logic unused_nodiv;
    assign unused_nodiv = clk;
    assign div_stall = 1'b0;
    assign div_done  = 1'b0;
    assign div_quot  = '0;
    assign div_rem   = '0;
    assign dbg_state = 2'd0;
`endif

    always_comb begin
        waddr_o    = waddr_i;
        wr_en_o    = wr_en_i && !is_div && !is_mt;
        stallreq_o = div_stall;
        hilo_we_o  = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        case (alusel_i)
            SEL_LOGIC: wdata_o = logic_res;
            SEL_SHIFT: wdata_o = shift_res;
            SEL_ARITH: wdata_o = arith_res;
            SEL_MOVE:  wdata_o = move_res;
            default:   wdata_o = '0;
        endcase
        if (div_done) begin
            hilo_we_o = 1'b1;
            hi_o      = div_rem;
            lo_o      = div_quot;
        end else if (aluop_i == OP_MTHI) begin
            hilo_we_o = 1'b1;
            hi_o      = reg1_i;
            lo_o      = lo_i;
        end else if (aluop_i == OP_MTLO) begin
            hilo_we_o = 1'b1;
            hi_o      = hi_i;
            lo_o      = reg1_i;
        end
        // A flushed instruction never commits to HI/LO.
        if (flush) begin
            hilo_we_o = 1'b0;
            hi_o      = '0;
            lo_o      = '0;
        end
        if (!rst) begin
            waddr_o    = '0;
            wr_en_o    = 1'b0;
            wdata_o    = '0;
            stallreq_o = 1'b0;
            hilo_we_o  = 1'b0;
            hi_o       = '0;
            lo_o       = '0;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Randomized scoreboard bench for ex_stage: drivers push per-cycle expected outputs, a negedge
// monitor pops and compares. Divide expectations follow EX_DIV_EN.
module tb_ex_stage;
    localparam int W = 104;
    localparam logic [7:0] OP_AND  = 8'b0010_0100, OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110, OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100, OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011, OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUBU = 8'b0010_0011, OP_SLT  = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU = 8'b0010_1011, OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI = 8'b0001_0001, OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO = 8'b0001_0011, OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011, OP_NOP  = 8'b0000_0000;
    localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE = 3'b011, SEL_ARITH = 3'b100;
    localparam logic [7:0] OP_TAB [0:15] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
        OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, 8'hFF};

    logic        clk = 1'b0;
    logic        rst, flush, wr_en_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
    logic [4:0]  waddr_i;
    logic [4:0]  waddr_o;
    logic        wr_en_o, hilo_we_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic [1:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .waddr_i(waddr_i), .wr_en_i(wr_en_i),
        .hi_i(hi_i), .lo_i(lo_i), .waddr_o(waddr_o), .wr_en_o(wr_en_o), .wdata_o(wdata_o),
        .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input logic st, input logic we, input logic [31:0] hv,
                                          input logic [31:0] lv, input logic wr,
                                          input logic [4:0] wa, input logic [31:0] wd);
        return {st, we, hv, lv, wr, wa, wd};
    endfunction

    function automatic logic [2:0] class_of(input logic [7:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NOR:     return SEL_LOGIC;
            OP_SLL, OP_SRL, OP_SRA:            return SEL_SHIFT;
            OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU: return SEL_ARITH;
            OP_MFHI, OP_MFLO:                  return SEL_MOVE;
            default:                           return SEL_NOP;
        endcase
    endfunction

    // Reference for every single-cycle operation, from the instruction semantics.
    function automatic logic [W-1:0] comb_model(input logic [7:0] op, input logic [2:0] sel,
                                                input logic [31:0] a, input logic [31:0] b,
                                                input logic [4:0] wa, input logic we,
                                                input logic [31:0] hv, input logic [31:0] lv,
                                                input logic fl, input logic rs);
        logic [31:0] res, ho, lo;
        logic        hw;
        int          sh;
        sh  = int'(a % 32);
        res = 32'd0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_SLL:  res = b << sh;
            OP_SRL:  res = b >> sh;
            OP_SRA:  res = 32'((longint'($signed(b))) / (64'sd1 << sh) - ((b[31] && (b % (32'd1 << sh)) != 0) ? 1 : 0));
            OP_ADDU: res = 32'(64'(a) + 64'(b));
            OP_SUBU: res = 32'(64'(a) + 64'(~b) + 64'd1);
            OP_SLT:  res = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            OP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
            OP_MFHI: res = hv;
            OP_MFLO: res = lv;
            default: res = 32'd0;
        endcase
        if (sel != class_of(op) || sel == SEL_NOP) res = 32'd0;
        hw = 1'b0; ho = 32'd0; lo = 32'd0;
        if (!fl && op == OP_MTHI) begin hw = 1'b1; ho = a; lo = lv; end
        if (!fl && op == OP_MTLO) begin hw = 1'b1; ho = hv; lo = a; end
        if (!rs) return '0;
        return pack(1'b0, hw, ho, lo, we && op != OP_MTHI && op != OP_MTLO && op != OP_DIV && op != OP_DIVU, wa, res);
    endfunction

    function automatic logic [63:0] div_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) return 64'd0;
        if (op == OP_DIVU) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    task automatic push(input logic [W-1:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic issue(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input string nm);
        aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b;
        waddr_i = 5'($urandom_range(1, 31)); wr_en_i = 1'($urandom_range(0, 1));
        hi_i = $urandom; lo_i = $urandom;
        push(comb_model(op, sel, a, b, waddr_i, wr_en_i, hi_i, lo_i, flush, rst), nm);
        @(posedge clk); #1;
    endtask

    // abort_kind: 0 none, 1 flush, 2 reset, applied abort_cyc cycles after issue.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int abort_cyc, input int abort_kind, input string nm);
        logic [63:0] r;
        int          n;
        aluop_i = op; alusel_i = SEL_NOP; reg1_i = a; reg2_i = b;
        waddr_i = 5'($urandom_range(1, 31)); wr_en_i = 1'b1;
        hi_i = $urandom; lo_i = $urandom;
`ifdef EX_DIV_EN
        n = (b == 32'd0) ? 2 : 33;
        for (int c = 0; c < n; c++) begin
            if (c == abort_cyc) begin
                if (abort_kind == 1) begin
                    flush = 1'b1;
                    push(pack(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, waddr_i, 32'd0), {nm, "_flush"});
                end else begin
                    rst = 1'b0;
                    push('0, {nm, "_rst"});
                end
                @(posedge clk); #1;
                flush = 1'b0; rst = 1'b1;
                issue(OP_NOP, SEL_NOP, 32'd0, 32'd0, {nm, "_after_abort"});
                return;
            end
            push(pack(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, waddr_i, 32'd0), {nm, "_stall"});
            @(posedge clk); #1;
        end
        r = div_ref(op, a, b);
        push(pack(1'b0, 1'b1, r[63:32], r[31:0], 1'b0, waddr_i, 32'd0), {nm, "_result"});
        @(posedge clk); #1;
`else
        r = div_ref(op, a, b);
        n = abort_cyc + abort_kind + int'(r[0]);
        push(pack(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, waddr_i, 32'd0), {nm, "_nodiv"});
        @(posedge clk); #1;
`endif
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e, act;
        string        nm;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {stallreq_o, hilo_we_o, hi_o, lo_o, wr_en_o, waddr_o, wdata_o};
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got stall=%0b hwe=%0b hi=%h lo=%h wr=%0b wa=%0d wd=%h, expected stall=%0b hwe=%0b hi=%h lo=%h wr=%0b wa=%0d wd=%h",
                         nm, act[103], act[102], act[101:70], act[69:38], act[37], act[36:32], act[31:0],
                         e[103], e[102], e[101:70], e[69:38], e[37], e[36:32], e[31:0]);
            end
        end
    end

    initial begin
        int idx;
        logic [31:0] a, b;
        logic [7:0]  op;
        rst = 1'b0; flush = 1'b0; aluop_i = OP_ADDU; alusel_i = SEL_ARITH;
        reg1_i = 32'd1; reg2_i = 32'd2; waddr_i = 5'd3; wr_en_i = 1'b1; hi_i = 32'd0; lo_i = 32'd0;
        @(posedge clk); #1;
        issue(OP_ADDU, SEL_ARITH, 32'h1234, 32'h5678, "reset_addu");
        issue(OP_MTHI, SEL_NOP, 32'hDEAD, 32'd0, "reset_mthi");
        rst = 1'b1;

        issue(OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'h0000_0002, "addu_wrap");
        issue(OP_SLT,  SEL_ARITH, 32'hFFFF_FFFF, 32'd1, "slt_signed");
        issue(OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, "sltu");
        issue(OP_SRA,  SEL_SHIFT, 32'd4, 32'h8000_0000, "sra");
        issue(OP_SUBU, SEL_ARITH, 32'd0, 32'd1, "subu_wrap");
        issue(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, "mfhi");
        issue(OP_MTHI, SEL_NOP, 32'hCAFE_F00D, 32'd0, "mthi");
        issue(OP_MTLO, SEL_NOP, 32'h0BAD_BEEF, 32'd0, "mtlo");
        issue(8'hFF, SEL_ARITH, 32'd5, 32'd6, "unknown_op");
        issue(OP_AND, SEL_NOP, 32'hFFFF, 32'hFF, "res_nop");

        for (int i = 0; i < 150; i++) begin
            idx = $urandom_range(0, 15);
            op  = OP_TAB[idx];
            a   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            flush = ($urandom_range(0, 7) == 0);
            issue(op, ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : class_of(op), a, b, "rand_comb");
            flush = 1'b0;
        end

        run_div(OP_DIV,  32'hFFFF_FFF9, 32'd2, -1, 0, "div_m7_2");
        run_div(OP_DIVU, 32'd100, 32'd0, -1, 0, "divu_by0");
        run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, -1, 0, "div_ovf");
        run_div(OP_DIVU, 32'd100, 32'd7, 10, 1, "divu_flush");
        run_div(OP_DIVU, 32'd100, 32'd7, -1, 0, "divu_100_7");
        run_div(OP_DIVU, 32'd100, 32'd7, 10, 2, "divu_rst");
        run_div(OP_DIVU, 32'hFFFF_FFFF, 32'd1, -1, 0, "divu_max");
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i == 2) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
            run_div($urandom_range(0, 1) ? OP_DIV : OP_DIVU, a, b, -1, 0, "rand_div");
        end
        issue(OP_OR, SEL_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, "or_after_div");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
